// File: rtl/rf_wb_arbiter.sv
// Round-robin write-back arbiter sharing one register-file write port among NUM_REQ writers.
// Optional read-port bypass of the in-flight write is enabled by defining RF_WB_BYPASS_EN.
module rf_wb_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic                      wb_stall,
`ifdef RF_WB_BYPASS_EN
  input  logic [ADDR_W-1:0]         byp_addr1,
  input  logic [ADDR_W-1:0]         byp_addr2,
  output logic                      byp_hit1,
  output logic                      byp_hit2,
  output logic [DATA_W-1:0]         byp_data1,
  output logic [DATA_W-1:0]         byp_data2,
`endif
  output logic                      wr_en,
  output logic [ADDR_W-1:0]         wr_addr,
  output logic [DATA_W-1:0]         wr_data
);

  localparam int PTR_W = $clog2(NUM_REQ);

  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic               wr_en_q;
  logic [ADDR_W-1:0]  wr_addr_q;
  logic [DATA_W-1:0]  wr_data_q;

  logic [NUM_REQ-1:0] gnt_vec;
  logic [PTR_W-1:0]   gnt_idx;
  logic               gnt_found;
  logic [ADDR_W-1:0]  win_addr;
  logic [DATA_W-1:0]  win_data;
  logic               xfer;

  // Two passes: first indices at/after the pointer, then the wrapped ones below it.
  always_comb begin
    gnt_vec   = '0;
    gnt_idx   = '0;
    gnt_found = 1'b0;
    win_addr  = '0;
    win_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!gnt_found && req_valid[i] && (PTR_W'(i) >= rr_ptr_q)) begin
        gnt_found  = 1'b1;
        gnt_idx    = PTR_W'(i);
        gnt_vec[i] = 1'b1;
        win_addr   = req_addr[i*ADDR_W +: ADDR_W];
        win_data   = req_data[i*DATA_W +: DATA_W];
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!gnt_found && req_valid[i]) begin
        gnt_found  = 1'b1;
        gnt_idx    = PTR_W'(i);
        gnt_vec[i] = 1'b1;
        win_addr   = req_addr[i*ADDR_W +: ADDR_W];
        win_data   = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign req_ready = (rst_n && !wb_stall) ? gnt_vec : '0;
  assign xfer      = |req_ready;

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (xfer) begin
      rr_ptr_d = (gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  // Writes to register 0 still update addr/data but never raise the enable.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr_q  <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      wr_en_q  <= xfer && (win_addr != '0);
      if (xfer) begin
        wr_addr_q <= win_addr;
        wr_data_q <= win_data;
      end
    end
  end

  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;

`ifdef RF_WB_BYPASS_EN
  assign byp_hit1  = wr_en_q && (wr_addr_q == byp_addr1) && (byp_addr1 != '0);
  assign byp_hit2  = wr_en_q && (wr_addr_q == byp_addr2) && (byp_addr2 != '0);
  assign byp_data1 = byp_hit1 ? wr_data_q : '0;
  assign byp_data2 = byp_hit2 ? wr_data_q : '0;
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter (3 requesters); bypass checks run when RF_WB_BYPASS_EN is defined.
module tb_rf_wb_arbiter;

  localparam int NUM_REQ = 3;
  localparam int ADDR_W  = 5;
  localparam int DATA_W  = 32;

  logic                      clk = 1'b0;
  logic                      rst_n;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      wb_stall;
  logic                      wr_en;
  logic [ADDR_W-1:0]         wr_addr;
  logic [DATA_W-1:0]         wr_data;
`ifdef RF_WB_BYPASS_EN
  logic [ADDR_W-1:0]         byp_addr1, byp_addr2;
  logic                      byp_hit1, byp_hit2;
  logic [DATA_W-1:0]         byp_data1, byp_data2;
`endif

  int n_checks = 0;
  int n_errors = 0;

  rf_wb_arbiter #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_ready (req_ready),
    .wb_stall  (wb_stall),
`ifdef RF_WB_BYPASS_EN
    .byp_addr1 (byp_addr1),
    .byp_addr2 (byp_addr2),
    .byp_hit1  (byp_hit1),
    .byp_hit2  (byp_hit2),
    .byp_data1 (byp_data1),
    .byp_data2 (byp_data2),
`endif
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    req_addr[i*ADDR_W +: ADDR_W] = a;
    req_data[i*DATA_W +: DATA_W] = d;
  endtask

  // Fixed per-requester payloads for the round-robin phases.
  logic [2:0]  rdy_seq  [3] = '{3'b001, 3'b010, 3'b100};
  logic [4:0]  addr_tbl [3] = '{5'd3, 5'd7, 5'd11};
  logic [31:0] data_tbl [3] = '{32'h0000_0300, 32'hDEAD_BEEF, 32'hB0B0_0011};

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    req_addr  = '0;
    req_data  = '0;
    wb_stall  = 1'b0;
`ifdef RF_WB_BYPASS_EN
    byp_addr1 = '0;
    byp_addr2 = '0;
`endif
    tick();
    req_valid = 3'b111;
    #1;
    check("rst_ready", 64'(req_ready), 64'(3'b000));
    tick();
    check("rst_wr_en", 64'(wr_en), 64'd0);
    check("rst_wr_addr", 64'(wr_addr), 64'd0);
    check("rst_wr_data", 64'(wr_data), 64'd0);

    // Single request from requester 1
    rst_n     = 1'b1;
    req_valid = 3'b010;
    set_req(1, 5'd7, 32'hDEAD_BEEF);
    #1;
    check("single_ready", 64'(req_ready), 64'(3'b010));
    tick();
    check("single_wr_en", 64'(wr_en), 64'd1);
    check("single_wr_addr", 64'(wr_addr), 64'd7);
    check("single_wr_data", 64'(wr_data), 64'(32'hDEAD_BEEF));

    // Pointer now 2: all valid must grant requester 2 first
    for (int i = 0; i < 3; i++) set_req(i, addr_tbl[i], data_tbl[i]);
    req_valid = 3'b111;
    #1;
    check("ptr2_ready", 64'(req_ready), 64'(3'b100));
    tick();
    check("ptr2_wr_addr", 64'(wr_addr), 64'(addr_tbl[2]));

    // Fairness from pointer 0: 0,1,2,0,1,2
    for (int k = 0; k < 6; k++) begin
      #1;
      check($sformatf("rr_ready_%0d", k), 64'(req_ready), 64'(rdy_seq[k % 3]));
      tick();
      check($sformatf("rr_wr_en_%0d", k), 64'(wr_en), 64'd1);
      check($sformatf("rr_wr_addr_%0d", k), 64'(wr_addr), 64'(addr_tbl[k % 3]));
      check($sformatf("rr_wr_data_%0d", k), 64'(wr_data), 64'(data_tbl[k % 3]));
    end

    // Address-0 write: accepted, enable stays low, payload still captured
    req_valid = 3'b001;
    set_req(0, 5'd0, 32'h0000_1234);
    #1;
    check("a0_ready", 64'(req_ready), 64'(3'b001));
    tick();
    check("a0_wr_en", 64'(wr_en), 64'd0);
    check("a0_wr_addr", 64'(wr_addr), 64'd0);
    check("a0_wr_data", 64'(wr_data), 64'(32'h0000_1234));

    // Stall three cycles with everyone valid; pointer must stay at 1
    set_req(0, addr_tbl[0], data_tbl[0]);
    req_valid = 3'b111;
    wb_stall  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      check($sformatf("stall_ready_%0d", k), 64'(req_ready), 64'd0);
      tick();
      check($sformatf("stall_wr_en_%0d", k), 64'(wr_en), 64'd0);
      check($sformatf("stall_wr_data_%0d", k), 64'(wr_data), 64'(32'h0000_1234));
    end
    wb_stall = 1'b0;
    #1;
    check("unstall_ready", 64'(req_ready), 64'(3'b010));
    tick();
    check("unstall_wr_en", 64'(wr_en), 64'd1);
    check("unstall_wr_addr", 64'(wr_addr), 64'(addr_tbl[1]));

    // Grant to 2, then reset mid-stream
    #1;
    check("pre_rst_ready", 64'(req_ready), 64'(3'b100));
    tick();
    rst_n = 1'b0;
    #1;
    check("mid_rst_ready", 64'(req_ready), 64'd0);
    tick();
    check("mid_rst_wr_en", 64'(wr_en), 64'd0);
    check("mid_rst_wr_addr", 64'(wr_addr), 64'd0);
    check("mid_rst_wr_data", 64'(wr_data), 64'd0);
    rst_n = 1'b1;
    #1;
    check("post_rst_ready", 64'(req_ready), 64'(3'b001));
    tick();
    check("post_rst_wr_en", 64'(wr_en), 64'd1);
    check("post_rst_wr_addr", 64'(wr_addr), 64'(addr_tbl[0]));

    // Pointer now 1; only requester 0 valid -> wraps to 0
    req_valid = 3'b001;
    set_req(0, 5'd9, 32'hA5A5_0001);
    #1;
    check("wrap_ready", 64'(req_ready), 64'(3'b001));
    tick();
    req_valid = 3'b000;
    check("byp_wr_addr", 64'(wr_addr), 64'd9);
`ifdef RF_WB_BYPASS_EN
    byp_addr1 = 5'd9;
    byp_addr2 = 5'd0;
    #1;
    check("byp_hit1", 64'(byp_hit1), 64'd1);
    check("byp_data1", 64'(byp_data1), 64'(32'hA5A5_0001));
    check("byp_hit2", 64'(byp_hit2), 64'd0);
    check("byp_data2", 64'(byp_data2), 64'd0);
    byp_addr2 = 5'd5;
    #1;
    check("byp_miss2", 64'(byp_hit2), 64'd0);
    tick();
    check("byp_idle_hit1", 64'(byp_hit1), 64'd0);
    check("byp_idle_data1", 64'(byp_data1), 64'd0);
`else
    tick();
`endif
    check("idle_wr_en", 64'(wr_en), 64'd0);
    check("idle_ready", 64'(req_ready), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
